// File: rtl/synth_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_bus_pkg
// Description : Shared types and bank codes for the synth parameter bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_SYX = 1'b1
    } req_t;

    localparam logic [2:0] BANK_ENV = 3'd0;
    localparam logic [2:0] BANK_OSC = 3'd1;
    localparam logic [2:0] BANK_M1  = 3'd2;
    localparam logic [2:0] BANK_M2  = 3'd3;
    localparam logic [2:0] BANK_COM = 3'd5;

    localparam int SEL_W = 5;

endpackage : synth_bus_pkg
`default_nettype wire

// File: rtl/param_bank_decode.sv
`default_nettype none
// ============================================================================
// Module      : param_bank_decode
// Description : Bank code to one-hot engine select {com,m2,m1,osc,env}.
// Revision    : 1.0 - initial release
// ============================================================================
module param_bank_decode
    import synth_bus_pkg::*;
(
    input  logic [2:0]       bank_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             unmapped_o
);

    always_comb begin
        sel_o      = '0;
        unmapped_o = 1'b0;
        case (bank_i)
            BANK_ENV: sel_o = 5'b00001;
            BANK_OSC: sel_o = 5'b00010;
            BANK_M1:  sel_o = 5'b00100;
            BANK_M2:  sel_o = 5'b01000;
            BANK_COM: sel_o = 5'b10000;
            default:  unmapped_o = 1'b1;
        endcase
    end

endmodule : param_bank_decode
`default_nettype wire

// File: rtl/param_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : param_bus_arbiter
// Description : Round-robin CPU/SysEx sequencer driving the synth engine
//               parameter bus with one-cycle strobes and read-latency wait.
// Revision    : 1.0 - initial release
// ============================================================================
module param_bus_arbiter
    import synth_bus_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 7
)
(
    input  logic              reg_clk,
    input  logic              reset_reg_n,
    input  logic              cpu_cs,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W+2:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_waitreq,
    input  logic              syx_req,
    input  logic              syx_we,
    input  logic [2:0]        syx_bank,
    input  logic [ADDR_W-1:0] syx_addr,
    input  logic [7:0]        syx_wdata,
    output logic              syx_ack,
    output logic [7:0]        syx_rdata,
    output logic [ADDR_W-1:0] adr,
    output logic              env_sel,
    output logic              osc_sel,
    output logic              m1_sel,
    output logic              m2_sel,
    output logic              com_sel,
    output logic              read,
    output logic              write,
    output logic [7:0]        synth_data_in,
    input  logic [7:0]        synth_data_out,
    output logic              bank_err,
    output logic              busy
);

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    arb_state_t        state_q, state_d;
    req_t              req_q, req_d;
    req_t              rr_last_q, rr_last_d;
    logic              we_q, we_d;
    logic              unmapped_q, unmapped_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              cpu_pend;
    logic              grant_syx;
    logic [2:0]        req_bank;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_unmapped;

    // A simultaneous rd+wr from the CPU is treated as a write.
    assign cpu_pend  = cpu_cs & (cpu_rd | cpu_wr);
    assign grant_syx = syx_req & (~cpu_pend | (rr_last_q == REQ_CPU));
    assign req_bank  = grant_syx ? syx_bank : cpu_addr[ADDR_W+2:ADDR_W];

    param_bank_decode u_decode (
        .bank_i     (req_bank),
        .sel_o      (dec_sel),
        .unmapped_o (dec_unmapped)
    );

    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            state_q    <= IDLE;
            req_q      <= REQ_CPU;
            rr_last_q  <= REQ_SYX;
            we_q       <= 1'b0;
            unmapped_q <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rr_last_q  <= rr_last_d;
            we_q       <= we_d;
            unmapped_q <= unmapped_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rr_last_d  = rr_last_q;
        we_d       = we_q;
        unmapped_d = unmapped_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_pend || syx_req) begin
                    state_d    = STROBE;
                    req_d      = grant_syx ? REQ_SYX : REQ_CPU;
                    we_d       = grant_syx ? syx_we : cpu_wr;
                    adr_d      = grant_syx ? syx_addr : cpu_addr[ADDR_W-1:0];
                    wdata_d    = grant_syx ? syx_wdata : cpu_wdata;
                    sel_d      = dec_sel;
                    unmapped_d = dec_unmapped;
                    // Cleared so writes and unmapped reads return zero.
                    rdata_d    = '0;
                end
            end
            STROBE: begin
                if (unmapped_q || we_q) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = synth_data_out;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                rr_last_d = req_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign adr           = adr_q;
    assign synth_data_in = wdata_q;
    assign env_sel       = sel_q[0];
    assign osc_sel       = sel_q[1];
    assign m1_sel        = sel_q[2];
    assign m2_sel        = sel_q[3];
    assign com_sel       = sel_q[4];

    assign read        = (state_q == STROBE) & ~unmapped_q & ~we_q;
    assign write       = (state_q == STROBE) & ~unmapped_q & we_q;
    assign bank_err    = (state_q == STROBE) & unmapped_q;
    assign busy        = (state_q != IDLE);
    assign cpu_waitreq = ~((state_q == DONE) & (req_q == REQ_CPU));
    assign syx_ack     = (state_q == DONE) & (req_q == REQ_SYX);
    assign cpu_rdata   = {24'd0, rdata_q};
    assign syx_rdata   = rdata_q;

endmodule : param_bus_arbiter
`default_nettype wire

// File: tb/tb_param_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_bus_arbiter
// Description : Directed self-checking bench for param_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_bus_arbiter;

    logic        reg_clk = 1'b0;
    logic        reset_reg_n = 1'b0;
    logic        cpu_cs = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_waitreq;
    logic        syx_req = 1'b0, syx_we = 1'b0;
    logic [2:0]  syx_bank = '0;
    logic [6:0]  syx_addr = '0;
    logic [7:0]  syx_wdata = '0;
    logic        syx_ack;
    logic [7:0]  syx_rdata;
    logic [6:0]  adr;
    logic        env_sel, osc_sel, m1_sel, m2_sel, com_sel;
    logic        read, write;
    logic [7:0]  synth_data_in;
    logic [7:0]  synth_data_out = '0;
    logic        bank_err, busy;

    int vectors = 0;
    int errors  = 0;

    param_bus_arbiter #(.RD_LAT(2), .ADDR_W(7)) dut (
        .reg_clk(reg_clk), .reset_reg_n(reset_reg_n),
        .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_waitreq(cpu_waitreq),
        .syx_req(syx_req), .syx_we(syx_we), .syx_bank(syx_bank),
        .syx_addr(syx_addr), .syx_wdata(syx_wdata),
        .syx_ack(syx_ack), .syx_rdata(syx_rdata),
        .adr(adr), .env_sel(env_sel), .osc_sel(osc_sel), .m1_sel(m1_sel),
        .m2_sel(m2_sel), .com_sel(com_sel), .read(read), .write(write),
        .synth_data_in(synth_data_in), .synth_data_out(synth_data_out),
        .bank_err(bank_err), .busy(busy)
    );

    always #5 reg_clk = ~reg_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge reg_clk);
    endtask

    // Selects packed as {com,m2,m1,osc,env}.
    function automatic logic [31:0] sels();
        return 32'({com_sel, m2_sel, m1_sel, osc_sel, env_sel});
    endfunction

    initial begin
        // Reset state
        tick();
        check("rst_waitreq", 32'(cpu_waitreq), 32'd1);
        check("rst_busy",    32'(busy),        32'd0);
        check("rst_strobes", 32'({read, write, bank_err, syx_ack}), 32'd0);
        check("rst_sels",    sels(),           32'd0);
        check("rst_rdata",   cpu_rdata,        32'd0);
        check("rst_adr",     32'(adr),         32'd0);

        // Both requesters held: grants alternate CPU,SYX,CPU,SYX
        reset_reg_n = 1'b1;
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = {3'd0, 7'h01}; cpu_wdata = 8'h10;
        syx_req = 1'b1; syx_we = 1'b1; syx_bank = 3'd2; syx_addr = 7'h02; syx_wdata = 8'h20;
        for (int i = 0; i < 4; i++) begin
            logic exp_cpu;
            exp_cpu = (i % 2 == 0);
            tick();
            check("arb_env_sel", 32'(env_sel), 32'(exp_cpu));
            check("arb_m1_sel",  32'(m1_sel),  32'(!exp_cpu));
            check("arb_data_in", 32'(synth_data_in), exp_cpu ? 32'h10 : 32'h20);
            check("arb_write",   32'(write),   32'd1);
            tick();
            check("arb_waitreq", 32'(cpu_waitreq), 32'(!exp_cpu));
            check("arb_syx_ack", 32'(syx_ack),     32'(!exp_cpu));
            tick();
            check("arb_idle",    32'(busy),        32'd0);
        end
        cpu_cs = 1'b0; cpu_wr = 1'b0; syx_req = 1'b0;

        // CPU write bank1 addr 0x12 data 0xA5
        tick();
        cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = {3'd1, 7'h12}; cpu_wdata = 8'hA5;
        tick();
        check("wr_sels",    sels(),             32'b00010);
        check("wr_write",   32'(write),         32'd1);
        check("wr_read",    32'(read),          32'd0);
        check("wr_adr",     32'(adr),           32'h12);
        check("wr_data_in", 32'(synth_data_in), 32'hA5);
        check("wr_wait_s",  32'(cpu_waitreq),   32'd1);
        tick();
        check("wr_waitreq", 32'(cpu_waitreq),   32'd0);
        check("wr_write_1", 32'(write),         32'd0);
        cpu_cs = 1'b0; cpu_wr = 1'b0;
        tick();
        check("wr_wait_hi", 32'(cpu_waitreq),   32'd1);
        check("wr_hold",    32'({osc_sel, adr}), 32'({1'b1, 7'h12}));

        // SysEx read bank5 addr 0x03, engine returns 0x7E after 2 cycles
        syx_req = 1'b1; syx_we = 1'b0; syx_bank = 3'd5; syx_addr = 7'h03;
        tick();
        check("rd_sels",    sels(),      32'b10000);
        check("rd_read",    32'(read),   32'd1);
        check("rd_adr",     32'(adr),    32'h03);
        tick();
        synth_data_out = 8'h11;
        check("rd_read_1",  32'(read),    32'd0);
        check("rd_ack_w1",  32'(syx_ack), 32'd0);
        tick();
        synth_data_out = 8'h7E;
        check("rd_ack_w2",  32'(syx_ack), 32'd0);
        tick();
        synth_data_out = 8'h22;
        check("rd_ack",     32'(syx_ack),   32'd1);
        check("rd_rdata",   32'(syx_rdata), 32'h7E);
        syx_req = 1'b0;
        tick();
        check("rd_ack_0",   32'(syx_ack), 32'd0);
        check("rd_idle",    32'(busy),    32'd0);

        // CPU read of unmapped bank 6
        cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = {3'd6, 7'h05};
        tick();
        check("ub_err",     32'(bank_err),      32'd1);
        check("ub_strobes", 32'({read, write}), 32'd0);
        check("ub_sels",    sels(),             32'd0);
        tick();
        check("ub_waitreq", 32'(cpu_waitreq),   32'd0);
        check("ub_rdata",   cpu_rdata,          32'd0);
        check("ub_err_1",   32'(bank_err),      32'd0);
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        tick();

        // Async reset while waiting on read latency
        cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = {3'd3, 7'h40};
        tick();
        check("ar_read",    32'(read),  32'd1);
        tick();
        check("ar_busy_w",  32'(busy),  32'd1);
        #1 reset_reg_n = 1'b0;
        #1;
        check("ar_busy",    32'(busy),        32'd0);
        check("ar_waitreq", 32'(cpu_waitreq), 32'd1);
        check("ar_strobes", 32'({read, write, bank_err, syx_ack}), 32'd0);
        check("ar_sels",    sels(),           32'd0);
        cpu_cs = 1'b0; cpu_rd = 1'b0;
        tick();
        reset_reg_n = 1'b1;
        syx_req = 1'b1; syx_we = 1'b1; syx_bank = 3'd0; syx_addr = 7'h05; syx_wdata = 8'h33;
        tick();
        check("pr_sels",    sels(),             32'b00001);
        check("pr_write",   32'(write),         32'd1);
        check("pr_data_in", 32'(synth_data_in), 32'h33);
        tick();
        check("pr_ack",     32'(syx_ack),       32'd1);
        syx_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_param_bus_arbiter
`default_nettype wire
